// File: rtl/rsa_frame_controller.sv
// rsa_frame_controller: collects a little-endian (value, exponent, modulus) request frame from
// received bytes, launches one modular exponentiation per frame, then streams the result back
// to the transmitter one byte at a time, least significant byte first.
module rsa_frame_controller #(
  parameter int MSG_WIDTH      = 16,
  parameter int KEY_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           rx_byte_in,
  input  logic                 rx_valid_in,
  output logic [MSG_WIDTH-1:0] value_out,
  output logic [KEY_WIDTH-1:0] exponent_out,
  output logic [KEY_WIDTH-1:0] modulus_out,
  output logic                 expmod_ready_out,
  input  logic [KEY_WIDTH-1:0] expmod_result_in,
  input  logic                 expmod_valid_in,
  output logic [7:0]           tx_byte_out,
  output logic                 tx_valid_out,
  input  logic                 tx_busy_in,
  output logic                 busy_out,
  output logic                 error_out
);

  localparam int FRAME_BITS = MSG_WIDTH + 2 * KEY_WIDTH;
  localparam int RX_BYTES   = (FRAME_BITS + 7) / 8;
  localparam int TX_BYTES   = (KEY_WIDTH + 7) / 8;
  localparam int RXC_W      = $clog2(RX_BYTES + 1);
  localparam int TXC_W      = $clog2(TX_BYTES + 1);
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RXC_W-1:0] RX_LAST  = RXC_W'(RX_BYTES - 1);
  localparam logic [TXC_W-1:0] TX_TOTAL = TXC_W'(TX_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_LAUNCH,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [RXC_W-1:0]        rx_count_q, rx_count_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [KEY_WIDTH-1:0]    shift_q, shift_d;
  logic [TXC_W-1:0]        tx_count_q, tx_count_d;
  logic                    ready_q, ready_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;

  logic [FRAME_BITS-1:0]   frame_ins;
  logic [RXC_W-1:0]        byte_idx;

  // Field slices are taken straight from the frame register so the core sees them the moment
  // the frame is complete; bits past the last field (padding in the final byte) are never stored.
  assign value_out        = frame_q[MSG_WIDTH-1:0];
  assign exponent_out     = frame_q[MSG_WIDTH +: KEY_WIDTH];
  assign modulus_out      = frame_q[MSG_WIDTH + KEY_WIDTH +: KEY_WIDTH];

  assign expmod_ready_out = ready_q;
  assign tx_valid_out     = tx_valid_q;
  assign tx_byte_out      = tx_byte_q;
  assign error_out        = error_q;
  assign busy_out         = busy_q;

  // Frame with the incoming byte merged at the current byte index; a new frame starts from zero.
  always_comb begin
    byte_idx  = (state_q == S_IDLE) ? '0 : rx_count_q;
    frame_ins = (state_q == S_IDLE) ? '0 : frame_q;
    for (int b = 0; b < FRAME_BITS; b++) begin
      if ((b / 8) == int'(byte_idx)) begin
        frame_ins[b] = rx_byte_in[3'(b % 8)];
      end
    end
  end

  // Sequencer next-state and datapath updates; pulse outputs default low every cycle.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rx_count_d = rx_count_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    tx_count_d = tx_count_q;
    ready_d    = 1'b0;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_in) begin
          frame_d    = frame_ins;
          rx_count_d = RXC_W'(1);
          timer_d    = '0;
          state_d    = S_RECV;
        end
      end

      S_RECV: begin
        if (rx_valid_in) begin
          frame_d    = frame_ins;
          rx_count_d = rx_count_q + 1'b1;
          timer_d    = '0;
          if (rx_count_q == RX_LAST) begin
            state_d = S_LAUNCH;
          end
        end else if (timer_q == TMR_LAST) begin
          error_d    = 1'b1;
          timer_d    = '0;
          rx_count_d = '0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_LAUNCH: begin
        rx_count_d = '0;
        if (modulus_out == '0) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (expmod_valid_in) begin
          shift_d    = expmod_result_in;
          tx_count_d = '0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (!tx_busy_in) begin
          tx_byte_d  = shift_q[7:0];
          tx_valid_d = 1'b1;
          shift_d    = shift_q >> 8;
          tx_count_d = tx_count_q + 1'b1;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if (tx_count_q < TX_TOTAL) begin
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs; reset aborts any frame or transmission at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      rx_count_q <= '0;
      timer_q    <= '0;
      shift_q    <= '0;
      tx_count_q <= '0;
      ready_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      rx_count_q <= rx_count_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      tx_count_q <= tx_count_d;
      ready_q    <= ready_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_rsa_frame_controller.sv
// tb_rsa_frame_controller: scoreboard bench for rsa_frame_controller. Instance A uses the
// default field widths, instance B the narrow 12/20-bit widths; both use a short timeout.
module tb_rsa_frame_controller;

  localparam int T_OUT = 50;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic [7:0]  rx_byte;
  logic        rx_valid_a;
  logic        rx_valid_b;

  logic [15:0] value_a;
  logic [31:0] exponent_a, modulus_a;
  logic        ready_a;
  logic [31:0] result_a = '0;
  logic        res_valid_a = 1'b0;
  logic [7:0]  tx_byte_a;
  logic        tx_valid_a;
  logic        tx_busy_a = 1'b0;
  logic        busy_a, error_a;

  logic [11:0] value_b;
  logic [19:0] exponent_b, modulus_b;
  logic        ready_b;
  logic [19:0] result_b = '0;
  logic        res_valid_b = 1'b0;
  logic [7:0]  tx_byte_b;
  logic        tx_valid_b;
  logic        tx_busy_b = 1'b0;
  logic        busy_b, error_b;

  rsa_frame_controller #(.MSG_WIDTH(16), .KEY_WIDTH(32), .TIMEOUT_CYCLES(T_OUT)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .rx_byte_in(rx_byte), .rx_valid_in(rx_valid_a),
    .value_out(value_a), .exponent_out(exponent_a), .modulus_out(modulus_a),
    .expmod_ready_out(ready_a), .expmod_result_in(result_a), .expmod_valid_in(res_valid_a),
    .tx_byte_out(tx_byte_a), .tx_valid_out(tx_valid_a), .tx_busy_in(tx_busy_a),
    .busy_out(busy_a), .error_out(error_a)
  );

  rsa_frame_controller #(.MSG_WIDTH(12), .KEY_WIDTH(20), .TIMEOUT_CYCLES(T_OUT)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rx_byte_in(rx_byte), .rx_valid_in(rx_valid_b),
    .value_out(value_b), .exponent_out(exponent_b), .modulus_out(modulus_b),
    .expmod_ready_out(ready_b), .expmod_result_in(result_b), .expmod_valid_in(res_valid_b),
    .tx_byte_out(tx_byte_b), .tx_valid_out(tx_valid_b), .tx_busy_in(tx_busy_b),
    .busy_out(busy_b), .error_out(error_b)
  );

  typedef struct {
    int          edge_no;
    logic [15:0] v;
    logic [31:0] e;
    logic [31:0] m;
  } launch_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_edge = 0;

  launch_t    launch_q[$];
  logic [7:0] tx_q_a[$];
  int         err_q_a[$];
  logic [7:0] tx_q_b[$];

  int launches_a = 0, errors_a = 0, strobes_a = 0;
  int launches_b = 0, errors_b = 0, strobes_b = 0;
  int bp_cycles = 0, busy_hold = 0;
  int core_cnt_a = 0, core_cnt_b = 0, res_edge_a = 0;
  bit first_tx_pending_a = 1'b0;
  logic [31:0] core_res_a = '0;
  logic [19:0] core_res_b = '0;
  logic [11:0] exp_v_b = '0;
  logic [19:0] exp_e_b = '0, exp_m_b = '0;

  // Edge counter: at a negedge it holds the number of the most recent rising edge.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                         input logic [63:0] m);
    logic [63:0] r, x;
    r = 64'd1 % m;
    x = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r;
  endfunction

  function automatic logic [79:0] packA(input logic [15:0] v, input logic [31:0] e,
                                        input logic [31:0] m);
    return {m, e, v};
  endfunction

  // One received byte to instance A or B, sampled at edge at_edge (or the next edge if earlier).
  task automatic applyStimulus(input logic [7:0] b, input bit to_b, input int at_edge);
    @(negedge clk_in);
    while (cyc + 1 < at_edge) @(negedge clk_in);
    rx_byte = b;
    if (to_b) rx_valid_b = 1'b1;
    else      rx_valid_a = 1'b1;
    last_edge = cyc + 1;
    @(negedge clk_in);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic sendBytesA(input logic [79:0] f, input int first, input int count);
    for (int i = first; i < first + count; i++) applyStimulus(f[8*i +: 8], 1'b0, 0);
  endtask

  // Scoreboard entries for a frame whose final byte was just sampled at last_edge.
  task automatic expectFrameA(input logic [15:0] v, input logic [31:0] e, input logic [31:0] m);
    launch_t l;
    logic [31:0] r;
    if (m == 32'd0) begin
      err_q_a.push_back(last_edge + 1);
    end else begin
      l.edge_no = last_edge + 1;
      l.v = v; l.e = e; l.m = m;
      launch_q.push_back(l);
      r = 32'(modexp(64'(v), 64'(e), 64'(m)));
      for (int i = 0; i < 4; i++) tx_q_a.push_back(r[8*i +: 8]);
    end
  endtask

  task automatic frameA(input logic [15:0] v, input logic [31:0] e, input logic [31:0] m);
    sendBytesA(packA(v, e, m), 0, 10);
    expectFrameA(v, e, m);
  endtask

  task automatic waitIdleA(input string tag);
    int n = 0;
    while ((busy_a || tx_q_a.size() > 0 || launch_q.size() > 0 || err_q_a.size() > 0)
           && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(n < 3000), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy_a), 64'd0);
  endtask

  // Monitors, core models and transmitter busy model for both instances.
  always @(negedge clk_in) begin : monitor
    launch_t l;
    res_valid_a = 1'b0;
    res_valid_b = 1'b0;
    if (rst_in) begin
      core_cnt_a = 0;
      core_cnt_b = 0;
      busy_hold = 0;
      tx_busy_a = 1'b0;
      first_tx_pending_a = 1'b0;
      tx_q_a.delete();
    end else begin
      if (ready_a) begin
        launches_a++;
        checkOutput("launch_expected", 64'(launch_q.size() > 0), 64'd1);
        if (launch_q.size() > 0) begin
          l = launch_q.pop_front();
          checkOutput("launch_edge", 64'(cyc), 64'(l.edge_no));
          checkOutput("value_out", 64'(value_a), 64'(l.v));
          checkOutput("exponent_out", 64'(exponent_a), 64'(l.e));
          checkOutput("modulus_out", 64'(modulus_a), 64'(l.m));
        end
        core_res_a = 32'(modexp(64'(value_a), 64'(exponent_a), 64'(modulus_a)));
        core_cnt_a = 3;
      end else if (core_cnt_a > 0) begin
        core_cnt_a--;
        if (core_cnt_a == 0) begin
          result_a = core_res_a;
          res_valid_a = 1'b1;
          res_edge_a = cyc + 1;
          first_tx_pending_a = 1'b1;
        end
      end
      if (error_a) begin
        errors_a++;
        checkOutput("error_expected", 64'(err_q_a.size() > 0), 64'd1);
        if (err_q_a.size() > 0) checkOutput("error_edge", 64'(cyc), 64'(err_q_a.pop_front()));
      end
      if (tx_valid_a) begin
        strobes_a++;
        checkOutput("tx_busy_at_strobe", 64'(tx_busy_a), 64'd0);
        checkOutput("tx_expected", 64'(tx_q_a.size() > 0), 64'd1);
        if (tx_q_a.size() > 0) checkOutput("tx_byte", 64'(tx_byte_a), 64'(tx_q_a.pop_front()));
        if (first_tx_pending_a) begin
          checkOutput("result_latency", 64'(cyc), 64'(res_edge_a + 1));
          first_tx_pending_a = 1'b0;
        end
        if (bp_cycles > 0) begin
          busy_hold = bp_cycles;
          tx_busy_a = 1'b1;
        end
      end else if (busy_hold > 0) begin
        busy_hold--;
        if (busy_hold == 0) tx_busy_a = 1'b0;
      end

      if (ready_b) begin
        launches_b++;
        checkOutput("b_value_out", 64'(value_b), 64'(exp_v_b));
        checkOutput("b_exponent_out", 64'(exponent_b), 64'(exp_e_b));
        checkOutput("b_modulus_out", 64'(modulus_b), 64'(exp_m_b));
        core_res_b = 20'(modexp(64'(value_b), 64'(exponent_b), 64'(modulus_b)));
        core_cnt_b = 3;
      end else if (core_cnt_b > 0) begin
        core_cnt_b--;
        if (core_cnt_b == 0) begin
          result_b = core_res_b;
          res_valid_b = 1'b1;
        end
      end
      if (error_b) errors_b++;
      if (tx_valid_b) begin
        strobes_b++;
        checkOutput("b_tx_expected", 64'(tx_q_b.size() > 0), 64'd1);
        if (tx_q_b.size() > 0) checkOutput("b_tx_byte", 64'(tx_byte_b), 64'(tx_q_b.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int l0, s0, e0, n;
    logic [79:0] f;
    logic [55:0] fb;
    logic [19:0] rb;

    rst_in = 1'b1;
    rx_byte = '0;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("rst_ready", 64'(ready_a), 64'd0);
    checkOutput("rst_tx_valid", 64'(tx_valid_a), 64'd0);
    checkOutput("rst_tx_byte", 64'(tx_byte_a), 64'd0);
    checkOutput("rst_busy", 64'(busy_a), 64'd0);
    checkOutput("rst_error", 64'(error_a), 64'd0);
    checkOutput("rst_value", 64'(value_a), 64'd0);
    checkOutput("rst_exponent", 64'(exponent_a), 64'd0);
    checkOutput("rst_modulus", 64'(modulus_a), 64'd0);
    rst_in = 1'b0;
    $display("[TB] reset released");

    // Nominal frame: 2^10 mod 1073 = 0x400, bytes 00 04 00 00.
    l0 = launches_a; s0 = strobes_a;
    frameA(16'h0002, 32'h0000_000A, 32'h0000_0431);
    waitIdleA("nominal");
    checkOutput("nominal_launches", 64'(launches_a - l0), 64'd1);
    checkOutput("nominal_strobes", 64'(strobes_a - s0), 64'd4);
    checkOutput("hold_value", 64'(value_a), 64'h0002);
    checkOutput("hold_modulus", 64'(modulus_a), 64'h0431);

    // Zero modulus: one error, no launch, no transmission.
    l0 = launches_a; s0 = strobes_a; e0 = errors_a;
    frameA(16'h0002, 32'h0000_000A, 32'h0000_0000);
    waitIdleA("zero_mod");
    checkOutput("zero_mod_errors", 64'(errors_a - e0), 64'd1);
    checkOutput("zero_mod_launches", 64'(launches_a - l0), 64'd0);
    checkOutput("zero_mod_strobes", 64'(strobes_a - s0), 64'd0);

    // Timeout after three bytes, then a full frame.
    e0 = errors_a; l0 = launches_a;
    sendBytesA(packA(16'h0005, 32'h3, 32'h1001), 0, 3);
    err_q_a.push_back(last_edge + T_OUT);
    waitIdleA("timeout");
    checkOutput("timeout_errors", 64'(errors_a - e0), 64'd1);
    frameA(16'h0007, 32'h0000_0011, 32'h0001_0001);
    waitIdleA("after_timeout");
    checkOutput("after_timeout_launches", 64'(launches_a - l0), 64'd1);

    // A byte landing on the timeout cycle keeps the frame alive.
    e0 = errors_a; l0 = launches_a;
    f = packA(16'h1234, 32'h0001_0001, 32'hFFFF_FFFB);
    sendBytesA(f, 0, 3);
    applyStimulus(f[24 +: 8], 1'b0, last_edge + T_OUT);
    sendBytesA(f, 4, 6);
    expectFrameA(16'h1234, 32'h0001_0001, 32'hFFFF_FFFB);
    waitIdleA("byte_wins");
    checkOutput("byte_wins_errors", 64'(errors_a - e0), 64'd0);
    checkOutput("byte_wins_launches", 64'(launches_a - l0), 64'd1);

    // Transmitter back-pressure: busy held 100 cycles after every strobe.
    s0 = strobes_a;
    bp_cycles = 100;
    frameA(16'h0003, 32'h0000_0007, 32'h9F3B_0C11);
    waitIdleA("backpressure");
    checkOutput("backpressure_strobes", 64'(strobes_a - s0), 64'd4);
    repeat (110) @(negedge clk_in);
    bp_cycles = 0;

    // Reset right after the second result byte.
    s0 = strobes_a;
    frameA(16'hBEEF, 32'h0000_001F, 32'hC0FF_EE01);
    n = 0;
    while (strobes_a < s0 + 2 && n < 500) begin
      @(posedge clk_in);
      n++;
    end
    checkOutput("strobes_before_reset", 64'(strobes_a - s0), 64'd2);
    #1 rst_in = 1'b1;
    #1;
    checkOutput("midrst_tx_valid", 64'(tx_valid_a), 64'd0);
    checkOutput("midrst_tx_byte", 64'(tx_byte_a), 64'd0);
    checkOutput("midrst_busy", 64'(busy_a), 64'd0);
    checkOutput("midrst_ready", 64'(ready_a), 64'd0);
    checkOutput("midrst_error", 64'(error_a), 64'd0);
    checkOutput("midrst_value", 64'(value_a), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (30) @(negedge clk_in);
    checkOutput("no_strobes_after_reset", 64'(strobes_a - s0), 64'd2);
    l0 = launches_a;
    frameA(16'h0002, 32'h0000_000A, 32'h0000_0431);
    waitIdleA("after_reset");
    checkOutput("after_reset_launches", 64'(launches_a - l0), 64'd1);

    // Narrow instance: 7 bytes in, padding nibble 0xA in the last byte, 3 bytes out.
    exp_v_b = 12'h9AB;
    exp_e_b = 20'h00005;
    exp_m_b = 20'hF0007;
    fb = {4'hA, exp_m_b, exp_e_b, exp_v_b};
    rb = 20'(modexp(64'(exp_v_b), 64'(exp_e_b), 64'(exp_m_b)));
    tx_q_b.push_back(rb[7:0]);
    tx_q_b.push_back(rb[15:8]);
    tx_q_b.push_back({4'h0, rb[19:16]});
    for (int i = 0; i < 7; i++) applyStimulus(fb[8*i +: 8], 1'b1, 0);
    n = 0;
    while ((busy_b || tx_q_b.size() > 0) && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("b_done", 64'(n < 1000), 64'd1);
    checkOutput("b_launches", 64'(launches_b), 64'd1);
    checkOutput("b_strobes", 64'(strobes_b), 64'd3);
    checkOutput("b_errors", 64'(errors_b), 64'd0);
    checkOutput("b_busy", 64'(busy_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
